// File: rtl/hamming_secded_decoder_if.sv
// Serial SECDED decoder bus: codeword bit stream in, corrected data stream
// and per-word error status out.
//   master : channel side, drives datain/din_valid/din_sof, observes results
//   slave  : decoder side, consumes the codeword stream, drives results
interface hamming_secded_decoder_if #(
  parameter int unsigned R = 4
);
  logic         datain;
  logic         din_valid;
  logic         din_sof;
  logic         dataout;
  logic         dout_valid;
  logic         word_done;
  logic         err_single;
  logic         err_double;
  logic [R-1:0] err_pos;

  modport master (
    output datain, din_valid, din_sof,
    input  dataout, dout_valid, word_done, err_single, err_double, err_pos
  );

  modport slave (
    input  datain, din_valid, din_sof,
    output dataout, dout_valid, word_done, err_single, err_double, err_pos
  );
endinterface

// File: rtl/hamming_secded_decoder.sv
// Serial extended-Hamming (SECDED) decoder.
// Collects one N-bit codeword (position 0 first), decodes it one cycle after
// the last bit lands, corrects single errors, flags double errors and shifts
// the K data bits out serially, d0 first, starting two cycles after the last
// codeword bit is captured.
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : slave side of hamming_secded_decoder_if (stream in, data/status out)
module hamming_secded_decoder #(
  parameter int unsigned R = 4
) (
  input logic                    clk,
  input logic                    reset,
  hamming_secded_decoder_if.slave bus
);
  localparam int unsigned N  = 1 << R;
  localparam int unsigned K  = N - R - 1;
  localparam int unsigned CW = $clog2(K + 1);

  // Codeword position of data bit j: the j-th non-power-of-two index >= 1.
  function automatic int unsigned data_pos(input int unsigned j);
    int unsigned k;
    int unsigned r;
    k = 0;
    r = 0;
    for (int unsigned i = 1; i < N; i++) begin
      if ((i & (i - 1)) != 0) begin
        if (k == j) r = i;
        k++;
      end
    end
    return r;
  endfunction

  logic [R-1:0]  bit_cnt_q;
  logic [N-1:0]  rx_q;
  logic          full_q;
  logic [K-1:0]  sr_q;
  logic [CW-1:0] out_cnt_q;
  logic          first_q;
  logic          dataout_q;
  logic          dout_valid_q;
  logic          word_done_q;
  logic          err_single_q;
  logic          err_double_q;
  logic [R-1:0]  err_pos_q;

  logic [R-1:0]  syn_d;
  logic          par_d;
  logic [N-1:0]  corr_d;
  logic [K-1:0]  data_d;

  // Syndrome, overall parity and single-bit correction of the held word.
  always_comb begin
    syn_d  = '0;
    par_d  = ^rx_q;
    corr_d = rx_q;
    for (int unsigned i = 1; i < N; i++) begin
      if (rx_q[i]) syn_d = syn_d ^ R'(i);
    end
    if (par_d) corr_d[syn_d] = ~corr_d[syn_d];
  end

  // Strip parity positions to recover d0..d(K-1).
  for (genvar j = 0; j < K; j++) begin : g_extract
    assign data_d[j] = corr_d[data_pos(j)];
  end

  // Collection, decode and serial output.
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt_q    <= '0;
      rx_q         <= '0;
      full_q       <= 1'b0;
      sr_q         <= '0;
      out_cnt_q    <= '0;
      first_q      <= 1'b0;
      dataout_q    <= 1'b0;
      dout_valid_q <= 1'b0;
      word_done_q  <= 1'b0;
      err_single_q <= 1'b0;
      err_double_q <= 1'b0;
      err_pos_q    <= '0;
    end else begin
      full_q <= 1'b0;
      if (bus.din_valid) begin
        if (bus.din_sof) begin
          // Resync: this bit is position 0, any partial word is abandoned.
          rx_q[0]   <= bus.datain;
          bit_cnt_q <= R'(1);
        end else begin
          rx_q[bit_cnt_q] <= bus.datain;
          bit_cnt_q       <= bit_cnt_q + R'(1);
          full_q          <= (bit_cnt_q == R'(N - 1));
        end
      end

      if (out_cnt_q != '0) begin
        dataout_q    <= sr_q[0];
        sr_q         <= sr_q >> 1;
        dout_valid_q <= 1'b1;
        word_done_q  <= first_q;
        first_q      <= 1'b0;
        out_cnt_q    <= out_cnt_q - CW'(1);
      end else begin
        dataout_q    <= 1'b0;
        dout_valid_q <= 1'b0;
        word_done_q  <= 1'b0;
      end

      // Completions are at least N cycles apart, so the previous word has
      // always drained by the time a new decode loads the shifter.
      if (full_q) begin
        sr_q         <= data_d;
        out_cnt_q    <= CW'(K);
        first_q      <= 1'b1;
        err_single_q <= par_d;
        err_double_q <= ~par_d & (syn_d != '0);
        err_pos_q    <= par_d ? syn_d : '0;
      end
    end
  end

  assign bus.dataout    = dataout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.word_done  = word_done_q;
  assign bus.err_single = err_single_q;
  assign bus.err_double = err_double_q;
  assign bus.err_pos    = err_pos_q;
endmodule

// File: tb/tb_hamming_secded_decoder.sv
// Directed bench for hamming_secded_decoder (R=4: N=16, K=11).
module tb_hamming_secded_decoder;
  logic clk;
  logic reset;
  int   total;
  int   bad;
  int   cyc;
  int   last_cap;
  int   first_cyc;
  int   nvalid;
  int   nwd;
  logic obits[$];

  hamming_secded_decoder_if #(.R(4)) bus ();

  hamming_secded_decoder #(.R(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Capture the output stream away from the active edge.
  always @(negedge clk) begin
    if (bus.dout_valid) begin
      obits.push_back(bus.dataout);
      nvalid++;
      if (bus.word_done) begin
        nwd++;
        first_cyc = cyc;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b, input logic sof);
    @(negedge clk);
    bus.din_valid = 1'b1;
    bus.datain    = b;
    bus.din_sof   = sof;
    last_cap      = cyc + 1;
  endtask

  // Idle cycle; din_sof/datain are toggled to show they are ignored.
  task automatic idle_cycle();
    @(negedge clk);
    bus.din_valid = 1'b0;
    bus.din_sof   = 1'b1;
    bus.datain    = 1'b1;
  endtask

  task automatic send_word(input logic [15:0] cw, input bit gaps, input bit use_sof);
    obits.delete();
    nvalid = 0;
    nwd    = 0;
    for (int i = 0; i < 16; i++) begin
      if (gaps && (i % 3 == 1)) begin
        for (int g = 0; g < 2; g++) idle_cycle();
      end
      send_bit(cw[i], use_sof && (i == 0));
    end
    @(negedge clk);
    bus.din_valid = 1'b0;
    bus.din_sof   = 1'b0;
    bus.datain    = 1'b0;
  endtask

  task automatic check_word(input string tag, input logic [10:0] exp_data,
                            input logic es, input logic ed, input logic [3:0] ep);
    logic [10:0] got;
    repeat (14) @(negedge clk);
    got = '0;
    for (int j = 0; j < obits.size() && j < 11; j++) got[j] = obits[j];
    chk({tag, ".data"}, 32'(got), 32'(exp_data));
    chk({tag, ".nvalid"}, 32'(nvalid), 32'd11);
    chk({tag, ".word_done"}, 32'(nwd), 32'd1);
    chk({tag, ".latency"}, 32'(first_cyc - last_cap), 32'd2);
    chk({tag, ".err_single"}, 32'(bus.err_single), 32'(es));
    chk({tag, ".err_double"}, 32'(bus.err_double), 32'(ed));
    chk({tag, ".err_pos"}, 32'(bus.err_pos), 32'(ep));
    chk({tag, ".idle"}, 32'({bus.dout_valid, bus.dataout, bus.word_done}), 32'd0);
  endtask

  initial begin
    int base;
    total = 0;
    bad = 0;
    cyc = 0;
    last_cap = 0;
    first_cyc = 0;
    nvalid = 0;
    nwd = 0;
    reset = 1'b1;
    bus.din_valid = 1'b0;
    bus.din_sof   = 1'b0;
    bus.datain    = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset.outputs", 32'({bus.dout_valid, bus.dataout, bus.word_done}), 32'd0);
    chk("reset.flags", 32'({bus.err_single, bus.err_double, bus.err_pos}), 32'd0);
    reset = 1'b0;

    // Clean words and single/double error cases.
    send_word(16'h0000, 1'b0, 1'b0);
    check_word("zero", 11'h000, 1'b0, 1'b0, 4'd0);
    send_word(16'h000F, 1'b0, 1'b1);
    check_word("d0", 11'h001, 1'b0, 1'b0, 4'd0);
    send_word(16'h002F, 1'b0, 1'b1);
    check_word("flip5", 11'h001, 1'b1, 1'b0, 4'd5);
    send_word(16'h000E, 1'b0, 1'b1);
    check_word("flip0", 11'h001, 1'b1, 1'b0, 4'd0);
    send_word(16'h006F, 1'b0, 1'b0);
    check_word("flip56", 11'h007, 1'b0, 1'b1, 4'd0);
    send_word(16'h0007, 1'b0, 1'b1);
    check_word("flip3", 11'h001, 1'b1, 1'b0, 4'd3);
    send_word(16'h8117, 1'b0, 1'b1);
    check_word("d10", 11'h400, 1'b0, 1'b0, 4'd0);
    send_word(16'h8317, 1'b0, 1'b1);
    check_word("d10flip9", 11'h400, 1'b1, 1'b0, 4'd9);

    // Stalls mid-word must not change the result.
    send_word(16'h002F, 1'b1, 1'b0);
    check_word("gaps", 11'h001, 1'b1, 1'b0, 4'd5);

    // Seven junk bits, then a sof-marked word: only the new word decodes.
    for (int i = 0; i < 7; i++) send_bit(1'b1, 1'b0);
    send_word(16'h000F, 1'b0, 1'b1);
    check_word("resync", 11'h001, 1'b0, 1'b0, 4'd0);

    // Reset while data is streaming out.
    send_word(16'h002F, 1'b0, 1'b1);
    for (int i = 0; i < 30 && nvalid < 3; i++) @(negedge clk);
    chk("rst_mid.reached", 32'(nvalid >= 3), 32'd1);
    chk("rst_mid.flag_before", 32'(bus.err_single), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid.dout_valid", 32'(bus.dout_valid), 32'd0);
    chk("rst_mid.flags", 32'({bus.err_single, bus.err_double, bus.err_pos}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    base = nvalid;
    repeat (15) @(negedge clk);
    chk("rst_mid.no_more", 32'(nvalid - base), 32'd0);

    // Decoder is fully usable again after the mid-output reset.
    send_word(16'h8317, 1'b0, 1'b0);
    check_word("post_rst", 11'h400, 1'b1, 1'b0, 4'd9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
